abs_diff_decoder: RTL and testbench

- Inverse of the absolute-difference datapath: rebuilds 8-bit samples from a stored reference plus a (sign, magnitude) difference.
- Sits at the receive/decode end of the difference-coded sample path.
- Valid/ready input and output, one-entry registered output.
- Optional DPCM chaining: each decoded sample becomes the next reference.

---
 rtl/abs_diff_decoder.sv | 105 ++++++++++
 tb/tb_abs_diff_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/abs_diff_decoder.sv
// Difference decoder: rebuilds W-bit samples from a reference plus a (sign, magnitude) difference.
// Saturating reconstruction, one-entry registered output, optional DPCM reference chaining.
module abs_diff_decoder #(
  parameter int W     = 8,
  parameter bit CHAIN = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ref_load,
  input  logic [W-1:0]     ref_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [W-1:0]     in_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_sat,
  output logic             ref_valid,
  output logic [CNT_W-1:0] sample_cnt
);

  // Handshake: a word transfers on any clock edge where valid & ready are both high.
  // Producers hold data stable while valid & !ready; in_ready never depends on in_valid.
  typedef enum logic [1:0] {
    NOREF = 2'd0,
    EMPTY = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           accept;
  logic [W:0]     sum_ext;
  logic [W:0]     diff_ext;
  logic [W-1:0]   dec_data;
  logic           dec_sat;
  logic [W-1:0]   ref_q;

  always_ff @(posedge clk) begin
    if (rst) state <= NOREF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NOREF:   if (ref_load) state_nxt = EMPTY;
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (!accept && out_ready) state_nxt = EMPTY;
      default: state_nxt = NOREF;
    endcase
  end

  always_comb begin
    ref_valid = (state != NOREF);
    out_valid = (state == FULL);
    in_ready  = ref_valid & (~out_valid | out_ready);
  end

  assign accept = in_valid & in_ready;

  // One extra bit catches overflow on add and borrow on subtract.
  always_comb begin
    sum_ext  = {1'b0, ref_q} + {1'b0, in_mag};
    diff_ext = {1'b0, ref_q} - {1'b0, in_mag};
    dec_data = '0;
    dec_sat  = 1'b0;
    if (in_sign) begin
      if (diff_ext[W]) begin
        dec_data = '0;
        dec_sat  = 1'b1;
      end else begin
        dec_data = diff_ext[W-1:0];
      end
    end else begin
      if (sum_ext[W]) begin
        dec_data = '1;
        dec_sat  = 1'b1;
      end else begin
        dec_data = sum_ext[W-1:0];
      end
    end
  end

  // ref_load wins over the chain update; the decode above always sees the old reference.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q      <= '0;
      out_data   <= '0;
      out_sat    <= 1'b0;
      sample_cnt <= '0;
    end else begin
      if (ref_load)              ref_q <= ref_in;
      else if (CHAIN && accept)  ref_q <= dec_data;
      if (accept) begin
        out_data   <= dec_data;
        out_sat    <= dec_sat;
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_abs_diff_decoder.sv
// Bench for abs_diff_decoder: a chaining 16-bit-counter instance and a fixed-reference 4-bit-counter
// instance share one stimulus stream; each has its own reference model and expected queue.
module tb_abs_diff_decoder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ref_load = 1'b0;
  logic [W-1:0] ref_in = '0;
  logic in_valid = 1'b0;
  logic in_sign = 1'b0;
  logic [W-1:0] in_mag = '0;
  logic out_ready = 1'b0;

  logic in_ready1, out_valid1, out_sat1, ref_valid1;
  logic [W-1:0] out_data1;
  logic [15:0] sample_cnt1;
  logic in_ready0, out_valid0, out_sat0, ref_valid0;
  logic [W-1:0] out_data0;
  logic [3:0] sample_cnt0;

  int n_vec = 0;
  int n_err = 0;

  logic [W:0] exp_q1[$];
  logic [W:0] exp_q0[$];

  int ref1, ref0, cnt1, cnt0;
  bit rv_m, ov_m;

  always #5 clk = ~clk;

  abs_diff_decoder #(.W(W), .CHAIN(1'b1), .CNT_W(16)) dut_chain (
    .clk(clk), .rst(rst), .ref_load(ref_load), .ref_in(ref_in),
    .in_valid(in_valid), .in_ready(in_ready1), .in_sign(in_sign), .in_mag(in_mag),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_sat(out_sat1), .ref_valid(ref_valid1), .sample_cnt(sample_cnt1)
  );

  abs_diff_decoder #(.W(W), .CHAIN(1'b0), .CNT_W(4)) dut_fixed (
    .clk(clk), .rst(rst), .ref_load(ref_load), .ref_in(ref_in),
    .in_valid(in_valid), .in_ready(in_ready0), .in_sign(in_sign), .in_mag(in_mag),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_sat(out_sat0), .ref_valid(ref_valid0), .sample_cnt(sample_cnt0)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference decode: plain integer arithmetic clamped to the sample range; returns {sat, data}.
  function automatic logic [W:0] decode(input int r, input bit sg, input int m);
    int s;
    int maxv;
    logic [W-1:0] d;
    maxv = (1 << W) - 1;
    s = sg ? (r - m) : (r + m);
    if (s > maxv) return {1'b1, W'(maxv)};
    if (s < 0)    return {1'b1, W'(0)};
    d = W'(s);
    return {1'b0, d};
  endfunction

  // One clock: check control outputs against the model, predict the handshake, advance the model.
  task automatic step();
    bit exp_rdy, acc;
    logic [W:0] d1, d0;
    @(negedge clk);
    if (rst) begin
      ref1 = 0; ref0 = 0; cnt1 = 0; cnt0 = 0; rv_m = 0; ov_m = 0;
      exp_q1.delete();
      exp_q0.delete();
    end else begin
      exp_rdy = rv_m && (!ov_m || out_ready);
      chk("in_ready_chain", in_ready1, exp_rdy);
      chk("in_ready_fixed", in_ready0, exp_rdy);
      chk("ref_valid_chain", ref_valid1, rv_m);
      chk("ref_valid_fixed", ref_valid0, rv_m);
      chk("out_valid_chain", out_valid1, ov_m);
      chk("out_valid_fixed", out_valid0, ov_m);
      chk("sample_cnt_chain", sample_cnt1, cnt1);
      chk("sample_cnt_fixed", sample_cnt0, cnt0);
      acc = in_valid && exp_rdy;
      if (acc) begin
        d1 = decode(ref1, in_sign, in_mag);
        d0 = decode(ref0, in_sign, in_mag);
        exp_q1.push_back(d1);
        exp_q0.push_back(d0);
        cnt1 = (cnt1 + 1) % 65536;
        cnt0 = (cnt0 + 1) % 16;
      end
      ov_m = acc ? 1'b1 : (out_ready ? 1'b0 : ov_m);
      if (ref_load) begin
        ref1 = ref_in; ref0 = ref_in; rv_m = 1'b1;
      end else if (acc) begin
        ref1 = d1[W-1:0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit iv, input bit sg, input int mg, input bit rl, input int ri, input bit ordy);
    in_valid = iv; in_sign = sg; in_mag = W'(mg);
    ref_load = rl; ref_in = W'(ri); out_ready = ordy;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("rst_out_data_chain", out_data1, 0);
    chk("rst_out_sat_chain", out_sat1, 0);
    chk("rst_out_data_fixed", out_data0, 0);
    chk("rst_out_sat_fixed", out_sat0, 0);
  endtask

  // Monitor: whenever an output is presented it must match the oldest expected entry; pop on transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid1) begin
        if (exp_q1.size() == 0) chk("unexpected_out_chain", 1, 0);
        else begin
          chk("out_chain", {out_sat1, out_data1}, exp_q1[0]);
          if (out_ready) void'(exp_q1.pop_front());
        end
      end
      if (out_valid0) begin
        if (exp_q0.size() == 0) chk("unexpected_out_fixed", 1, 0);
        else begin
          chk("out_fixed", {out_sat0, out_data0}, exp_q0[0]);
          if (out_ready) void'(exp_q0.pop_front());
        end
      end
    end
  end

  initial begin
    do_reset();
    // No reference yet: words are refused.
    repeat (3) cyc(1, 0, 5, 0, 0, 1);
    cyc(0, 0, 0, 1, 100, 1);
    // Basic decode against ref 100.
    cyc(1, 0, 20, 0, 0, 1);
    cyc(1, 1, 30, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // Saturation high, chained decode, saturation low.
    cyc(0, 0, 0, 1, 200, 1);
    cyc(1, 0, 80, 0, 0, 1);
    cyc(1, 1, 50, 0, 0, 1);
    cyc(0, 0, 0, 1, 10, 1);
    cyc(1, 1, 30, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // Backpressure: hold, then drain and accept together.
    cyc(1, 0, 7, 0, 0, 0);
    repeat (5) cyc(1, 0, 9, 0, 0, 0);
    cyc(1, 1, 3, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // ref_load coincident with an accept.
    cyc(0, 0, 0, 1, 100, 1);
    cyc(1, 0, 5, 1, 50, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // Reset while FULL and stalled.
    cyc(1, 0, 1, 0, 0, 0);
    do_reset();
    cyc(1, 0, 1, 0, 0, 0);
    // 17 accepts wrap the 4-bit counter to 1.
    cyc(0, 0, 0, 1, 128, 1);
    repeat (17) cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("cnt4_wrap", sample_cnt0, 1);
    chk("cnt16_count", sample_cnt1, 17);
    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 500) == 0) do_reset();
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(0, 255),
          $urandom_range(0, 30) == 0, $urandom_range(0, 255),
          $urandom_range(0, 3) != 0);
    end
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    chk("drain_chain", exp_q1.size(), 0);
    chk("drain_fixed", exp_q0.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
